// File: rtl/wash_program_ctrl_pkg.sv
// Shared types and constants for the wash programme sequencer.
package wash_program_ctrl_pkg;

    // Phase encoding is also the value shown on the display port.
    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFill   = 4'd1,
        StWash   = 4'd2,
        StDrain  = 4'd3,
        StRfill  = 4'd4,
        StRinse  = 4'd5,
        StRdrain = 4'd6,
        StSpin   = 4'd7,
        StDone   = 4'd8,
        StAbortd = 4'd9,
        StFault  = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ProgNormal    = 2'd0,
        ProgQuick     = 2'd1,
        ProgHeavy     = 2'd2,
        ProgNormalAlt = 2'd3
    } prog_e;

    localparam int unsigned RinsesStd   = 1;
    localparam int unsigned RinsesHeavy = 2;

    // Wash length scales with the programme: quick halves it, heavy doubles it.
    function automatic int unsigned wash_ticks(prog_e prog, int unsigned wash_t);
        case (prog)
            ProgQuick: return wash_t >> 1;
            ProgHeavy: return wash_t << 1;
            default:   return wash_t;
        endcase
    endfunction

    // States in which pause and abort are honoured.
    function automatic logic is_run(state_e s);
        return s inside {StFill, StWash, StDrain, StRfill, StRinse, StRdrain, StSpin};
    endfunction

endpackage

// File: rtl/wash_program_ctrl_if.sv
// Front panel, level sensors and actuator drives of one drum.
interface wash_program_ctrl_if;
    logic       start;
    logic [1:0] prog_sel;
    logic       pause;
    logic       abort;
    logic       door_closed;
    logic       level_full;
    logic       level_empty;
    logic       fill_valve;
    logic       drain_pump;
    logic       motor_wash;
    logic       motor_spin;
    logic       door_lock;
    logic       done;
    logic       fault;
    logic [3:0] phase;

    modport master (
        output start, prog_sel, pause, abort, door_closed, level_full, level_empty,
        input  fill_valve, drain_pump, motor_wash, motor_spin, door_lock, done, fault, phase
    );

    modport slave (
        input  start, prog_sel, pause, abort, door_closed, level_full, level_empty,
        output fill_valve, drain_pump, motor_wash, motor_spin, door_lock, done, fault, phase
    );
endinterface

// File: rtl/wash_program_ctrl_phase_timer.sv
// Tick prescaler plus phase down-counter shared by all timed phases.
module wash_program_ctrl_phase_timer #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned TW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          hold,
    input  logic [TW-1:0] load_val,
    output logic          zero
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_q;
    logic [TW-1:0] cnt_q;
    logic          tick;

    assign tick = !hold && (pre_q == PW'(TICK_DIV - 1));
    // High on the tick that takes the count to zero, so a phase of N ticks
    // leaves exactly N*TICK_DIV cycles after its entry edge.
    assign zero = tick && (cnt_q <= TW'(1));

    // Prescaler and counter restart on load, freeze on hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            pre_q <= '0;
            cnt_q <= load_val;
        end else if (!hold) begin
            if (tick) begin
                pre_q <= '0;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - TW'(1);
                end
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end
endmodule

// File: rtl/wash_program_ctrl.sv
// Programme sequencer for one drum: fill, wash, drain, rinse(s), spin, done.
module wash_program_ctrl #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned WASH_T   = 8,
    parameter int unsigned RINSE_T  = 4,
    parameter int unsigned SPIN_T   = 6,
    parameter int unsigned FILL_TO  = 10,
    parameter int unsigned DRAIN_TO = 10,
    parameter int unsigned TW       = 8
) (
    input logic                clk,
    input logic                reset,
    wash_program_ctrl_if.slave bus
);
    import wash_program_ctrl_pkg::*;

    state_e        state_q, state_d;
    prog_e         prog_q;
    logic [1:0]    rinse_q;
    logic          pause_q, pause_d;
    logic          run, locked, tmr_zero, tmr_load;
    logic [TW-1:0] tmr_val;
    logic          fill_valve_q, drain_pump_q, motor_wash_q, motor_spin_q;
    logic          door_lock_q, done_q, fault_q;

    assign run      = is_run(state_q);
    assign locked   = run || (state_q == StAbortd);
    assign pause_d  = bus.pause && is_run(state_d);
    assign tmr_load = (state_d != state_q);

    // Next state, in priority order: door, abort, timeout, pause, normal flow.
    always_comb begin
        state_d = state_q;
        if (locked && !bus.door_closed) begin
            state_d = StFault;
        end else if (run && bus.abort) begin
            state_d = StAbortd;
        end else if (tmr_zero &&
                     (state_q inside {StFill, StRfill, StDrain, StRdrain, StAbortd})) begin
            state_d = StFault;
        end else if (!pause_q) begin
            case (state_q)
                StIdle:   if (bus.start && bus.door_closed) state_d = StFill;
                StFill:   if (bus.level_full) state_d = StWash;
                StWash:   if (tmr_zero) state_d = StDrain;
                StDrain:  if (bus.level_empty) state_d = StRfill;
                StRfill:  if (bus.level_full) state_d = StRinse;
                StRinse:  if (tmr_zero) state_d = StRdrain;
                StRdrain: if (bus.level_empty) state_d = (rinse_q > 2'd1) ? StRfill : StSpin;
                StSpin:   if (tmr_zero) state_d = StDone;
                StDone:   state_d = StIdle;
                StAbortd: if (bus.level_empty) state_d = StIdle;
                StFault:  if (bus.abort && bus.level_empty) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Duration or sensor timeout loaded on entry to the next state.
    always_comb begin
        tmr_val = '0;
        case (state_d)
            StFill, StRfill:            tmr_val = TW'(FILL_TO);
            StDrain, StRdrain, StAbortd: tmr_val = TW'(DRAIN_TO);
            StWash:                     tmr_val = TW'(wash_ticks(prog_q, WASH_T));
            StRinse:                    tmr_val = TW'(RINSE_T);
            StSpin:                     tmr_val = TW'(SPIN_T);
            default:                    tmr_val = '0;
        endcase
    end

    wash_program_ctrl_phase_timer #(
        .TICK_DIV (TICK_DIV),
        .TW       (TW)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .hold     (pause_q),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State, programme latch, rinse counter and registered Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            prog_q       <= ProgNormal;
            rinse_q      <= '0;
            pause_q      <= 1'b0;
            fill_valve_q <= 1'b0;
            drain_pump_q <= 1'b0;
            motor_wash_q <= 1'b0;
            motor_spin_q <= 1'b0;
            door_lock_q  <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
            if (state_q == StIdle && state_d == StFill) begin
                prog_q  <= prog_e'(bus.prog_sel);
                rinse_q <= (prog_e'(bus.prog_sel) == ProgHeavy) ? 2'(RinsesHeavy)
                                                                 : 2'(RinsesStd);
            end else if (state_q == StRdrain && (state_d inside {StRfill, StSpin})) begin
                rinse_q <= rinse_q - 2'd1;
            end
            fill_valve_q <= (state_d inside {StFill, StRfill}) && !pause_d;
            drain_pump_q <= ((state_d inside {StDrain, StRdrain, StSpin}) && !pause_d) ||
                            (state_d == StAbortd);
            motor_wash_q <= (state_d inside {StWash, StRinse}) && !pause_d;
            motor_spin_q <= (state_d == StSpin) && !pause_d;
            door_lock_q  <= !(state_d inside {StIdle, StDone, StFault});
            done_q       <= (state_d == StDone);
            fault_q      <= (state_d == StFault);
        end
    end

    assign bus.fill_valve = fill_valve_q;
    assign bus.drain_pump = drain_pump_q;
    assign bus.motor_wash = motor_wash_q;
    assign bus.motor_spin = motor_spin_q;
    assign bus.door_lock  = door_lock_q;
    assign bus.done       = done_q;
    assign bus.fault      = fault_q;
    assign bus.phase      = state_q;
endmodule

// File: tb/tb_wash_program_ctrl.sv
// Directed bench for wash_program_ctrl with a short tick (4 cycles).
module tb_wash_program_ctrl;
    localparam logic [3:0] P_IDLE   = 4'd0;
    localparam logic [3:0] P_FILL   = 4'd1;
    localparam logic [3:0] P_WASH   = 4'd2;
    localparam logic [3:0] P_DRAIN  = 4'd3;
    localparam logic [3:0] P_RFILL  = 4'd4;
    localparam logic [3:0] P_RINSE  = 4'd5;
    localparam logic [3:0] P_RDRAIN = 4'd6;
    localparam logic [3:0] P_SPIN   = 4'd7;
    localparam logic [3:0] P_DONE   = 4'd8;
    localparam logic [3:0] P_ABORTD = 4'd9;
    localparam logic [3:0] P_FAULT  = 4'd10;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    wash_program_ctrl_if bus ();

    wash_program_ctrl #(
        .TICK_DIV (4),
        .WASH_T   (4),
        .RINSE_T  (2),
        .SPIN_T   (3),
        .FILL_TO  (5),
        .DRAIN_TO (5),
        .TW       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ph(input string tag, input logic [3:0] ph, input int budget);
        int n = 0;
        while (bus.phase !== ph && n < budget) begin
            tick1();
            n++;
        end
        chk(tag, bus.phase, ph);
    endtask

    // Counts cycles spent in ph from the current (entry) sample point.
    task automatic measure(input string tag, input logic [3:0] ph, input int budget,
                           input int exp);
        int n = 0;
        while (bus.phase === ph && n < budget) begin
            tick1();
            n++;
        end
        chk(tag, n, exp);
    endtask

    // Sensor answers two cycles into a fill or drain phase.
    task automatic do_fill();
        tick1();
        tick1();
        bus.level_full  = 1'b1;
        bus.level_empty = 1'b0;
        tick1();
    endtask

    task automatic do_drain();
        tick1();
        tick1();
        bus.level_full  = 1'b0;
        bus.level_empty = 1'b1;
        tick1();
    endtask

    task automatic to_spin(input logic [1:0] prog);
        bus.prog_sel = prog;
        bus.start    = 1'b1;
        tick1();
        bus.start = 1'b0;
        do_fill();
        wait_ph("ts_drain", P_DRAIN, 60);
        do_drain();
        do_fill();
        wait_ph("ts_rdrain", P_RDRAIN, 30);
        do_drain();
        chk("ts_spin", bus.phase, P_SPIN);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.prog_sel    = 2'd0;
        bus.pause       = 1'b0;
        bus.abort       = 1'b0;
        bus.door_closed = 1'b0;
        bus.level_full  = 1'b0;
        bus.level_empty = 1'b0;
        tick1();
        chk("reset_outs", {bus.fill_valve, bus.drain_pump, bus.motor_wash, bus.motor_spin,
                           bus.door_lock, bus.done, bus.fault, bus.phase}, 0);
        tick1();
        reset           = 1'b0;
        bus.door_closed = 1'b1;
        bus.level_empty = 1'b1;

        // Normal programme.
        bus.prog_sel = 2'd0;
        bus.start    = 1'b1;
        tick1();
        bus.start = 1'b0;
        chk("n_fill", bus.phase, P_FILL);
        chk("n_fill_valve", bus.fill_valve, 1);
        chk("n_lock", bus.door_lock, 1);
        do_fill();
        chk("n_wash", bus.phase, P_WASH);
        chk("n_motor_wash", bus.motor_wash, 1);
        measure("n_wash_len", P_WASH, 100, 16);
        chk("n_drain", bus.phase, P_DRAIN);
        chk("n_drain_pump", bus.drain_pump, 1);
        do_drain();
        chk("n_rfill", bus.phase, P_RFILL);
        do_fill();
        chk("n_rinse", bus.phase, P_RINSE);
        measure("n_rinse_len", P_RINSE, 100, 8);
        do_drain();
        chk("n_spin", bus.phase, P_SPIN);
        chk("n_motor_spin", {bus.motor_spin, bus.drain_pump}, 2'b11);
        measure("n_spin_len", P_SPIN, 100, 12);
        chk("n_done", bus.phase, P_DONE);
        chk("n_done_pulse", bus.done, 1);
        chk("n_done_unlock", bus.door_lock, 0);
        tick1();
        chk("n_idle", bus.phase, P_IDLE);
        chk("n_done_low", bus.done, 0);

        // Heavy programme: double wash, two rinses.
        bus.prog_sel = 2'd2;
        bus.start    = 1'b1;
        tick1();
        bus.start = 1'b0;
        do_fill();
        measure("h_wash_len", P_WASH, 100, 32);
        do_drain();
        chk("h_rfill1", bus.phase, P_RFILL);
        do_fill();
        measure("h_rinse1_len", P_RINSE, 100, 8);
        do_drain();
        chk("h_rfill2", bus.phase, P_RFILL);
        do_fill();
        measure("h_rinse2_len", P_RINSE, 100, 8);
        do_drain();
        chk("h_spin", bus.phase, P_SPIN);
        measure("h_spin_len", P_SPIN, 100, 12);
        tick1();
        chk("h_idle", bus.phase, P_IDLE);

        // Quick programme: half wash, then abort out of DRAIN.
        bus.prog_sel = 2'd1;
        bus.start    = 1'b1;
        tick1();
        bus.start = 1'b0;
        do_fill();
        measure("q_wash_len", P_WASH, 100, 8);
        bus.abort = 1'b1;
        tick1();
        bus.abort = 1'b0;
        chk("q_abortd", bus.phase, P_ABORTD);
        do_drain();
        chk("q_idle", bus.phase, P_IDLE);

        // Pause 10 cycles mid-wash.
        bus.prog_sel = 2'd0;
        bus.start    = 1'b1;
        tick1();
        bus.start = 1'b0;
        do_fill();
        n = 0;
        repeat (5) begin
            tick1();
            n++;
        end
        bus.pause = 1'b1;
        tick1();
        n++;
        chk("p_motor_off", bus.motor_wash, 0);
        chk("p_lock_on", bus.door_lock, 1);
        repeat (9) begin
            tick1();
            n++;
        end
        chk("p_still_wash", bus.phase, P_WASH);
        bus.pause = 1'b0;
        tick1();
        n++;
        chk("p_motor_on", bus.motor_wash, 1);
        while (bus.phase === P_WASH && n < 100) begin
            tick1();
            n++;
        end
        chk("p_wash_len", n, 26);
        bus.abort = 1'b1;
        tick1();
        bus.abort = 1'b0;
        do_drain();
        chk("p_idle", bus.phase, P_IDLE);

        // Fill timeout.
        bus.start = 1'b1;
        tick1();
        bus.start = 1'b0;
        measure("f_fill_len", P_FILL, 100, 20);
        chk("f_fault", {bus.fault, bus.phase}, {1'b1, P_FAULT});
        chk("f_act_off", {bus.fill_valve, bus.drain_pump, bus.door_lock}, 0);
        bus.level_empty = 1'b0;
        bus.abort       = 1'b1;
        tick1();
        chk("f_hold_fault", bus.phase, P_FAULT);
        bus.level_empty = 1'b1;
        tick1();
        bus.abort = 1'b0;
        chk("f_idle", {bus.fault, bus.phase}, {1'b0, P_IDLE});

        // Abort in RINSE.
        bus.start = 1'b1;
        tick1();
        bus.start = 1'b0;
        do_fill();
        wait_ph("a_drain", P_DRAIN, 60);
        do_drain();
        do_fill();
        chk("a_rinse", bus.phase, P_RINSE);
        tick1();
        bus.abort = 1'b1;
        tick1();
        bus.abort = 1'b0;
        chk("a_abortd", bus.phase, P_ABORTD);
        chk("a_acts", {bus.drain_pump, bus.motor_wash, bus.door_lock}, 3'b101);
        tick1();
        tick1();
        chk("a_still", {bus.phase, bus.drain_pump}, {P_ABORTD, 1'b1});
        bus.level_full  = 1'b0;
        bus.level_empty = 1'b1;
        tick1();
        chk("a_idle", {bus.phase, bus.done}, {P_IDLE, 1'b0});

        // Door opened in SPIN.
        to_spin(2'd1);
        tick1();
        tick1();
        bus.door_closed = 1'b0;
        tick1();
        chk("d_fault", {bus.fault, bus.phase}, {1'b1, P_FAULT});
        chk("d_act_off", {bus.fill_valve, bus.drain_pump, bus.motor_wash, bus.motor_spin,
                          bus.door_lock}, 0);
        bus.door_closed = 1'b1;
        bus.abort       = 1'b1;
        tick1();
        bus.abort = 1'b0;
        chk("d_idle", bus.phase, P_IDLE);

        // Asynchronous reset mid-SPIN, then start with door open.
        to_spin(2'd0);
        tick1();
        chk("r_spinning", bus.motor_spin, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_async", {bus.fill_valve, bus.drain_pump, bus.motor_wash, bus.motor_spin,
                        bus.door_lock, bus.done, bus.fault, bus.phase}, 0);
        tick1();
        reset           = 1'b0;
        bus.door_closed = 1'b0;
        bus.start       = 1'b1;
        repeat (3) tick1();
        chk("r_door_open_idle", {bus.phase, bus.door_lock}, {P_IDLE, 1'b0});
        bus.start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
